decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 37 +++
 rtl/decode_stage_reg_file.sv | 42 ++++
 rtl/decode_stage.sv | 133 +++++++++++++
 tb/tb_decode_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and payload types for the ID stage of the
// 8-bit pipeline. Holds opcode and ALU-control encodings, instruction field
// bit positions, data/register-address widths and the ID/EX payload struct.
package decode_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned REG_ADDR_W = 3;

  // Instruction field bit positions: [7:6] opcode, [5:3] rd, [2:0] rs
  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RD_MSB = 5;
  localparam int unsigned RD_LSB = 3;
  localparam int unsigned RS_MSB = 2;
  localparam int unsigned RS_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SLL  = 2'b01;
  localparam logic [OP_W-1:0] OP_MOVI = 2'b10;
  localparam logic [OP_W-1:0] OP_NOP  = 2'b11;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SLL = 1'b1;

  // ID/EX pipeline register payload
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  control;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
  } idex_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: NUM_REGS x 8-bit register file, one write port, two
// combinational read ports with write-through (a read of the address being
// written this cycle returns the new data).
// Ports:
//   clk, reset           clock, asynchronous active-high reset (clears all)
//   we, waddr, wdata     write port, written on the rising edge
//   raddr_a / rdata_a    read port A
//   raddr_b / rdata_b    read port B
module reg_file
  import decode_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage; a write coinciding with reset is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with write-through
  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode and operand fetch. Decodes the 8-bit
// instruction, reads operands from the register file, resolves hazards
// against the instruction in EX and loads the ID/EX pipeline register.
// Build option: define DECODE_EX_FWD_EN to bypass alu_result from EX (never
// stalls); leave it undefined to stall one cycle on an EX dependency instead.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready  fetch handshake, instruction word
//   alu_result                  combinational result of the EX instruction
//   wb_en/wb_addr/wb_data       register-file write port from writeback
//   ex_valid/ex_a/ex_b/ex_control/ex_rd/ex_wr_en  ID/EX register outputs
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  instr_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b,
  output logic                  ex_control,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_wr_en
);

  logic [OP_W-1:0]       op;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs;
  logic [DATA_W-1:0]     rf_a;
  logic [DATA_W-1:0]     rf_b;
  logic [DATA_W-1:0]     opnd_a;
  logic [DATA_W-1:0]     opnd_b;
  logic                  stall;
  idex_t                 idex_q;
  idex_t                 idex_d;

  assign op = instr[OP_MSB:OP_LSB];
  assign rd = instr[RD_MSB:RD_LSB];
  assign rs = instr[RS_MSB:RS_LSB];

  reg_file #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rd),
    .rdata_a (rf_a),
    .raddr_b (rs),
    .rdata_b (rf_b)
  );

`ifdef DECODE_EX_FWD_EN
  // EX bypass outranks WB write-through: the EX producer is younger
  assign opnd_a = (idex_q.valid && idex_q.wr_en && (idex_q.rd == rd)) ? alu_result : rf_a;
  assign opnd_b = (idex_q.valid && idex_q.wr_en && (idex_q.rd == rs)) ? alu_result : rf_b;
  assign stall  = 1'b0;
`else
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;

  assign opnd_a = rf_a;
  assign opnd_b = rf_b;
  // Hold a register-reading instruction one cycle while its source is in EX;
  // the producer then sits in WB and write-through supplies the value
  assign stall  = instr_valid && idex_q.valid && idex_q.wr_en &&
                  ((op == OP_ADD) || (op == OP_SLL)) &&
                  ((idex_q.rd == rd) || (idex_q.rd == rs));
`endif

  assign instr_ready = ~reset & ~stall;

  // Next ID/EX contents; anything not accepted becomes a bubble
  always_comb begin
    idex_d = '0;
    if (instr_valid && instr_ready) begin
      idex_d.valid = 1'b1;
      idex_d.rd    = rd;
      case (op)
        OP_ADD: begin
          idex_d.a       = opnd_a;
          idex_d.b       = opnd_b;
          idex_d.control = ALU_ADD;
          idex_d.wr_en   = 1'b1;
        end
        OP_SLL: begin
          idex_d.a       = opnd_a;
          idex_d.b       = opnd_b;
          idex_d.control = ALU_SLL;
          idex_d.wr_en   = 1'b1;
        end
        OP_MOVI: begin
          idex_d.b       = DATA_W'(rs);
          idex_d.control = ALU_ADD;
          idex_d.wr_en   = 1'b1;
        end
        OP_NOP: begin
          idex_d.control = ALU_ADD;
        end
        default: begin
          idex_d.wr_en = 1'b0;
        end
      endcase
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid   = idex_q.valid;
  assign ex_a       = idex_q.a;
  assign ex_b       = idex_q.b;
  assign ex_control = idex_q.control;
  assign ex_rd      = idex_q.rd;
  assign ex_wr_en   = idex_q.wr_en;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage. Works for
// both builds; the hazard steps follow the build's forwarding option.
module tb_decode_stage;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] alu_result;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       ex_valid;
  logic [7:0] ex_a;
  logic [7:0] ex_b;
  logic       ex_control;
  logic [2:0] ex_rd;
  logic       ex_wr_en;

  int n_chk  = 0;
  int n_fail = 0;

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_result  (alu_result),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_control  (ex_control),
    .ex_rd       (ex_rd),
    .ex_wr_en    (ex_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic [2:0] rd,
                        input logic we);
    chk({tag, ".valid"}, 8'(ex_valid), 8'(v));
    chk({tag, ".a"}, ex_a, a);
    chk({tag, ".b"}, ex_b, b);
    chk({tag, ".control"}, 8'(ex_control), 8'(c));
    chk({tag, ".rd"}, 8'(ex_rd), 8'(rd));
    chk({tag, ".wr_en"}, 8'(ex_wr_en), 8'(we));
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = 8'h8D;
    alu_result  = 8'h00;
    wb_en       = 1'b0;
    wb_addr     = 3'd0;
    wb_data     = 8'h00;

    // Reset state, instruction presented but never accepted
    tick();
    tick();
    chk("rst.ready", 8'(instr_ready), 8'h0);
    chk_ex("rst", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // MOVI r1,5
    reset = 1'b0;
    instr = 8'h8D;
    #1;
    chk("movi.ready", 8'(instr_ready), 8'h1);
    tick();
    chk_ex("movi", 1'b1, 8'h00, 8'h05, 1'b0, 3'd1, 1'b1);

    // Preload r2=3, r3=2 through WB while bubbles flow
    instr_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h03;
    tick();
    chk("bubble.valid", 8'(ex_valid), 8'h0);
    chk("bubble.wr_en", 8'(ex_wr_en), 8'h0);
    wb_addr = 3'd3; wb_data = 8'h02;
    tick();
    wb_en = 1'b0;

    // SLL r2,r3
    instr_valid = 1'b1;
    instr = 8'h53;
    tick();
    chk_ex("sll", 1'b1, 8'h03, 8'h02, 1'b1, 3'd2, 1'b1);

    // Back-to-back MOVI r1,5 then ADD r1,r1
    instr = 8'h8D;
    tick();
    instr = 8'h09;
    alu_result = 8'h05;
    #1;
`ifdef DECODE_EX_FWD_EN
    chk("raw1.ready", 8'(instr_ready), 8'h1);
    tick();
    chk_ex("raw1", 1'b1, 8'h05, 8'h05, 1'b0, 3'd1, 1'b1);
`else
    chk("raw1.stall_ready", 8'(instr_ready), 8'h0);
    tick();
    chk("raw1.bubble_valid", 8'(ex_valid), 8'h0);
    chk("raw1.bubble_wr_en", 8'(ex_wr_en), 8'h0);
    alu_result = 8'hEE;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h05;
    #1;
    chk("raw1.ready", 8'(instr_ready), 8'h1);
    tick();
    wb_en = 1'b0;
    chk_ex("raw1", 1'b1, 8'h05, 8'h05, 1'b0, 3'd1, 1'b1);
`endif

    // WB write-through: ADD r4,r4 with r4 written this cycle
    instr = 8'h24;
    alu_result = 8'h00;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h7F;
    tick();
    wb_en = 1'b0;
    chk_ex("wthru", 1'b1, 8'h7F, 8'h7F, 1'b0, 3'd4, 1'b1);

    // EX and WB both target r6: EX value wins
    instr = 8'hB1;
    tick();
    chk_ex("movi6", 1'b1, 8'h00, 8'h01, 1'b0, 3'd6, 1'b1);
    instr = 8'h36;
    alu_result = 8'h11;
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 8'h22;
`ifdef DECODE_EX_FWD_EN
    tick();
`else
    #1;
    chk("exwb.stall_ready", 8'(instr_ready), 8'h0);
    tick();
    chk("exwb.bubble_valid", 8'(ex_valid), 8'h0);
    wb_data = 8'h11;
    alu_result = 8'hEE;
    tick();
`endif
    wb_en = 1'b0;
    chk_ex("exwb", 1'b1, 8'h11, 8'h11, 1'b0, 3'd6, 1'b1);

    // NOP
    instr = 8'hC0;
    alu_result = 8'h00;
    tick();
    chk("nop.valid", 8'(ex_valid), 8'h1);
    chk("nop.wr_en", 8'(ex_wr_en), 8'h0);
    chk("nop.a", ex_a, 8'h00);
    chk("nop.b", ex_b, 8'h00);

    // Reset mid-operation with a pending WB write to r5
    instr = 8'h8D;
    tick();
    chk("prerst.valid", 8'(ex_valid), 8'h1);
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h55;
    reset = 1'b1;
    #1;
    chk("midrst.valid", 8'(ex_valid), 8'h0);
    chk("midrst.ready", 8'(instr_ready), 8'h0);
    tick();
    reset = 1'b0;
    wb_en = 1'b0;
    chk("midrst.wr_en", 8'(ex_wr_en), 8'h0);

    // r5 write dropped, r2 cleared by reset
    instr = 8'h2D;
    tick();
    chk_ex("r5", 1'b1, 8'h00, 8'h00, 1'b0, 3'd5, 1'b1);
    instr = 8'h12;
    tick();
    chk_ex("r2", 1'b1, 8'h00, 8'h00, 1'b0, 3'd2, 1'b1);

    instr_valid = 1'b0;
    tick();
    chk("end.valid", 8'(ex_valid), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
